// File: rtl/pad_cfg_pkg.sv
// Shared field map, commit FSM states and reset constants for the pad ring controller.
`timescale 1ns/1ps
package pad_cfg_pkg;

  localparam logic [4:0] F_OUT   = 5'd0;
  localparam logic [4:0] F_OE    = 5'd1;
  localparam logic [4:0] F_CS    = 5'd2;
  localparam logic [4:0] F_SL    = 5'd3;
  localparam logic [4:0] F_IE    = 5'd4;
  localparam logic [4:0] F_PU    = 5'd5;
  localparam logic [4:0] F_PD    = 5'd6;
  localparam logic [4:0] F_BIN   = 5'd7;
  localparam logic [4:0] F_IN_PU = 5'd8;
  localparam logic [4:0] F_IN_PD = 5'd9;
  localparam logic [4:0] F_IIN   = 5'd10;
  localparam logic [4:0] F_CTRL  = 5'd15;

  localparam logic [63:0] IE_RST = '1;

  typedef enum logic [1:0] {
    IDLE,
    DROP,
    SETTLE,
    APPLY
  } state_e;

  function automatic logic [63:0] word_mask(input logic hi);
    return hi ? 64'hFFFF_FFFF_0000_0000
              : 64'h0000_0000_FFFF_FFFF;
  endfunction

endpackage

// File: rtl/pad_cfg_sync.sv
// Parameterised-width two-flop synchronizer for asynchronous pad inputs.
`timescale 1ns/1ps
module pad_cfg_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Pad ring config controller: shadow regs, OE-safe commit sequence, pad readback.
// Define PAD_CFG_SYNC_EN to pass pad inputs through 2-flop synchronizers.
`timescale 1ns/1ps
module pad_cfg_ctrl #(
  parameter int NUM_BIDIR_PADS = 37,
  parameter int NUM_INPUT_PADS = 16,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req,
  input  logic                      we,
  input  logic [5:0]                addr,
  input  logic [31:0]               wdata,
  output logic                      ack,
  output logic [31:0]               rdata,
  output logic                      busy,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd,
  input  logic [NUM_INPUT_PADS-1:0] input_in,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd
);

  import pad_cfg_pkg::*;

  localparam int NB = NUM_BIDIR_PADS;
  localparam int NI = NUM_INPUT_PADS;
  localparam logic [7:0] SET_LAST = 8'(SETTLE_CYCLES - 1);

  state_e state_q, state_d;
  logic [7:0] cnt_q;
  logic armed_q;

  logic [NB-1:0] sh_oe, sh_cs, sh_sl, sh_ie, sh_pu, sh_pd;
  logic [NI-1:0] sh_ipu, sh_ipd;
  logic [NB-1:0] bin_s;
  logic [NI-1:0] iin_s;

`ifdef PAD_CFG_SYNC_EN
  pad_cfg_sync #(.W(NB)) u_bsync (
    .clk (clk),
    .rst (rst),
    .d   (bidir_in),
    .q   (bin_s)
  );
  pad_cfg_sync #(.W(NI)) u_isync (
    .clk (clk),
    .rst (rst),
    .d   (input_in),
    .q   (iin_s)
  );
`else
  assign bin_s = bidir_in;
  assign iin_s = input_in;
`endif

  logic [4:0]  field;
  logic        hi;
  logic        sh_fld, ctrl_fld;
  logic        accept, wr, commit;
  logic [63:0] m64, v64, rd64;
  logic [NB-1:0] bm, bv;
  logic [NI-1:0] im, iv;
  logic [NB-1:0] ie_rst_v;

  assign field    = addr[5:1];
  assign hi       = addr[0];
  assign busy     = (state_q != IDLE);
  assign ctrl_fld = (field == F_CTRL);
  assign sh_fld   = (field inside {F_OE, F_CS, F_SL, F_IE, F_PU,
                                   F_PD, F_IN_PU, F_IN_PD});

  // Config writes wait for the sequence to finish; reads never stall.
  assign accept = req & armed_q & ~ack
                & ~(we & busy & (sh_fld | ctrl_fld));
  assign wr     = accept & we;
  assign commit = wr & ctrl_fld & wdata[0];

  assign m64      = word_mask(hi);
  assign v64      = {wdata, wdata};
  assign bm       = m64[NB-1:0];
  assign bv       = v64[NB-1:0];
  assign im       = m64[NI-1:0];
  assign iv       = v64[NI-1:0];
  assign ie_rst_v = IE_RST[NB-1:0];

  always_comb begin
    rd64 = '0;
    case (field)
      F_OUT:   rd64 = 64'(bidir_out);
      F_OE:    rd64 = 64'(sh_oe);
      F_CS:    rd64 = 64'(sh_cs);
      F_SL:    rd64 = 64'(sh_sl);
      F_IE:    rd64 = 64'(sh_ie);
      F_PU:    rd64 = 64'(sh_pu);
      F_PD:    rd64 = 64'(sh_pd);
      F_BIN:   rd64 = 64'(bin_s);
      F_IN_PU: rd64 = 64'(sh_ipu);
      F_IN_PD: rd64 = 64'(sh_ipd);
      F_IIN:   rd64 = 64'(iin_s);
      F_CTRL:  rd64 = {63'd0, busy};
      default: rd64 = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (commit) state_d = DROP;
      DROP:    state_d = SETTLE;
      SETTLE:  if (cnt_q == SET_LAST) state_d = APPLY;
      APPLY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack     <= 1'b0;
      rdata   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == SETTLE) ? cnt_q + 8'd1 : 8'd0;
      ack     <= accept;
      rdata   <= accept ? (hi ? rd64[63:32] : rd64[31:0]) : 32'd0;
      armed_q <= ~req | (armed_q & ~accept);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_oe  <= '0;
      sh_cs  <= '0;
      sh_sl  <= '0;
      sh_ie  <= ie_rst_v;
      sh_pu  <= '0;
      sh_pd  <= '0;
      sh_ipu <= '0;
      sh_ipd <= '0;
    end else if (wr) begin
      if (field == F_OE)    sh_oe  <= (sh_oe  & ~bm) | (bv & bm);
      if (field == F_CS)    sh_cs  <= (sh_cs  & ~bm) | (bv & bm);
      if (field == F_SL)    sh_sl  <= (sh_sl  & ~bm) | (bv & bm);
      if (field == F_IE)    sh_ie  <= (sh_ie  & ~bm) | (bv & bm);
      if (field == F_PU)    sh_pu  <= (sh_pu  & ~bm) | (bv & bm);
      if (field == F_PD)    sh_pd  <= (sh_pd  & ~bm) | (bv & bm);
      if (field == F_IN_PU) sh_ipu <= (sh_ipu & ~im) | (iv & im);
      if (field == F_IN_PD) sh_ipd <= (sh_ipd & ~im) | (iv & im);
    end
  end

  // OE only ever narrows before the settle window; new config lands in APPLY.
  always_ff @(posedge clk) begin
    if (rst) begin
      bidir_out <= '0;
      bidir_oe  <= '0;
      bidir_cs  <= '0;
      bidir_sl  <= '0;
      bidir_ie  <= ie_rst_v;
      bidir_pu  <= '0;
      bidir_pd  <= '0;
      input_pu  <= '0;
      input_pd  <= '0;
    end else begin
      if (wr && field == F_OUT)
        bidir_out <= (bidir_out & ~bm) | (bv & bm);
      if (commit)
        bidir_oe <= bidir_oe & sh_oe;
      if (state_q == APPLY) begin
        bidir_oe <= sh_oe;
        bidir_cs <= sh_cs;
        bidir_sl <= sh_sl;
        bidir_ie <= sh_ie;
        bidir_pu <= sh_pu;
        bidir_pd <= sh_pd;
        input_pu <= sh_ipu;
        input_pd <= sh_ipd;
      end
    end
  end

endmodule

// File: tb/tb_pad_cfg_ctrl.sv
// Directed self-checking bench for pad_cfg_ctrl.
`timescale 1ns/1ps
module tb_pad_cfg_ctrl;

  localparam int NB = 37;
  localparam int NI = 16;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [5:0]    addr = '0;
  logic [31:0]   wdata = '0;
  logic          ack;
  logic [31:0]   rdata;
  logic          busy;
  logic [NB-1:0] bidir_in = '0;
  logic [NB-1:0] bidir_out, bidir_oe, bidir_cs, bidir_sl;
  logic [NB-1:0] bidir_ie, bidir_pu, bidir_pd;
  logic [NI-1:0] input_in = '0;
  logic [NI-1:0] input_pu, input_pd;

  int ntest = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  pad_cfg_ctrl #(
    .NUM_BIDIR_PADS (NB),
    .NUM_INPUT_PADS (NI),
    .SETTLE_CYCLES  (SC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .bidir_in  (bidir_in),
    .bidir_out (bidir_out),
    .bidir_oe  (bidir_oe),
    .bidir_cs  (bidir_cs),
    .bidir_sl  (bidir_sl),
    .bidir_ie  (bidir_ie),
    .bidir_pu  (bidir_pu),
    .bidir_pd  (bidir_pd),
    .input_in  (input_in),
    .input_pu  (input_pu),
    .input_pd  (input_pd)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntest++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [5:0] a,
                     input logic [31:0] d,
                     output logic [31:0] rd, output int lat);
    logic got;
    got = 1'b0;
    rd  = '0;
    lat = 0;
    @(posedge clk);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int i = 0; i < 64 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack) begin
        got = 1'b1;
        rd  = rdata;
      end
    end
    req = 1'b0;
    if (!got) chk("bus_timeout", 64'd0, 64'd1);
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    bus(1'b1, a, d, rd, lat);
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a,
                        input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    bus(1'b0, a, 32'd0, rd, lat);
    chk(tag, 64'(rd), 64'(exp));
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (!busy) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!done) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int lat, bcnt, oelat;
    logic bad;

    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_oe", 64'(bidir_oe), 64'd0);
    chk("rst_ie", 64'(bidir_ie), 64'h1F_FFFF_FFFF);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rd_chk("rd_ie_w0", 6'd8, 32'hFFFF_FFFF);
    rd_chk("rd_ie_w1", 6'd9, 32'h0000_001F);

    // 2: shadow OE then commit latency
    wr(6'd2, 32'h5);
    chk("oe_no_commit", 64'(bidir_oe), 64'd0);
    rd_chk("rd_sh_oe", 6'd2, 32'h5);
    bus(1'b1, 6'd30, 32'h1, rd, lat);
    bcnt  = busy ? 1 : 0;
    oelat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (busy) bcnt++;
      if (oelat == 0 && bidir_oe == 37'h5) oelat = k;
    end
    chk("commit_lat", 64'(oelat), 64'(SC + 2));
    chk("busy_len", 64'(bcnt), 64'(SC + 2));

    // 3: OE drops before widening
    wr(6'd2, 32'hF);
    wr(6'd30, 32'h1);
    wait_idle();
    chk("oe_f", 64'(bidir_oe), 64'hF);
    wr(6'd2, 32'h33);
    bus(1'b1, 6'd30, 32'h1, rd, lat);
    chk("drop_oe", 64'(bidir_oe), 64'h3);
    bad = 1'b0;
    for (int k = 0; k < 20 && busy; k++) begin
      if (bidir_oe != 37'h3) bad = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("no_early_oe", 64'(bad), 64'd0);
    chk("busy_done", 64'(busy), 64'd0);
    chk("apply_oe", 64'(bidir_oe), 64'h33);

    // 4: shadow write during busy stalls
    wr(6'd30, 32'h1);
    bus(1'b1, 6'd10, 32'hA, rd, lat);
    chk("pu_stalled", 64'(lat > 1), 64'd1);
    chk("pu_ack_idle", 64'(busy), 64'd0);
    chk("pu_live_old", 64'(bidir_pu), 64'd0);
    rd_chk("rd_sh_pu", 6'd10, 32'hA);
    wr(6'd30, 32'h1);
    wait_idle();
    chk("pu_applied", 64'(bidir_pu), 64'hA);

    // 5: OUT direct write and pad readback
    wr(6'd0, 32'h1234_5678);
    wr(6'd1, 32'hFFFF_FFFF);
    chk("out_live", 64'(bidir_out), 64'h1F_1234_5678);
    rd_chk("rd_out_w1", 6'd1, 32'h1F);
    bidir_in = 37'h10_0000_0000;
    input_in = 16'hBEEF;
    repeat (4) @(posedge clk);
    #1;
    rd_chk("rd_bin_w1", 6'd15, 32'h10);
    rd_chk("rd_iin_w0", 6'd20, 32'hBEEF);
    bidir_in = '0;
`ifdef PAD_CFG_SYNC_EN
    rd_chk("rd_bin_sync", 6'd15, 32'h10);
`else
    rd_chk("rd_bin_direct", 6'd15, 32'h0);
`endif
    repeat (4) @(posedge clk);
    #1;
    rd_chk("rd_bin_low", 6'd15, 32'h0);

    // 6: reset mid-commit, then unmapped field
    wr(6'd30, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_oe", 64'(bidir_oe), 64'd0);
    chk("mid_rst_ie", 64'(bidir_ie), 64'h1F_FFFF_FFFF);
    chk("mid_rst_out", 64'(bidir_out), 64'd0);
    chk("mid_rst_pu", 64'(bidir_pu), 64'd0);
    bus(1'b1, 6'd24, 32'hFFFF_FFFF, rd, lat);
    chk("f12_acked", 64'(lat), 64'd1);
    chk("f12_no_busy", 64'(busy), 64'd0);
    rd_chk("rd_f12", 6'd24, 32'h0);
    rd_chk("rd_sh_oe_rst", 6'd2, 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
